interrupt_controller: RTL

Interrupt initiator for the 16-bit MIPS core. It synchronises and edge-detects external request lines, arbitrates by fixed priority, and drives the one-cycle `interrupt` pulse into the jump control logic, which then vectors the PC to 16'hF000. It exposes the winning source ID to the ISR and blocks further interrupts until the ISR's RET opcode is seen on `op`. It sits beside the jump control block in the fetch/decode stage.

---
 rtl/mips_defines_pkg.sv | 16 +
 rtl/irq_sync_edge.sv | 27 ++
 rtl/interrupt_controller.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_defines_pkg.sv
// Shared MIPS-16 definitions: opcodes used by jump control and the interrupt
// initiator, the interrupt vector, and the interrupt FSM state encoding.
package mips_defines_pkg;

   localparam logic [5:0]  OP_RET     = 6'b010000;
   localparam logic [15:0] IRQ_VECTOR = 16'hF000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FIRE    = 3'd1,
      ST_ENTRY   = 3'd2,
      ST_SERVICE = 3'd3,
      ST_GUARD   = 3'd4
   } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector comparing the synchronised value with its previous sample.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= (sync << 1) | SYNC_STAGES'(req);
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt initiator: synchronised edge capture, fixed-priority arbitration
// (bit 0 highest) and a non-nesting IDLE/FIRE/ENTRY/SERVICE/GUARD sequencer.
module interrupt_controller
   import mips_defines_pkg::*;
#(
   parameter int N_IRQ       = 4,
   parameter int ID_W        = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_req,
   input  logic [5:0]       op,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   output logic             interrupt,
   output logic [ID_W-1:0]  irq_id,
   output logic             irq_active,
   output logic [N_IRQ-1:0] pending,
   output logic [N_IRQ-1:0] mask
);

   irq_state_e       state, state_nxt;
   logic             entry_cnt;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] eligible;
   logic [N_IRQ-1:0] win_onehot;
   logic [ID_W-1:0]  win_id;
   logic             fire;
   logic             ret_ok;

   for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .reset (reset),
         .req   (irq_req[i]),
         .rise  (rise[i])
      );
   end

   assign eligible   = pending & mask;
   // Isolate the lowest set bit: that is the highest-priority eligible source.
   assign win_onehot = eligible & (~eligible + N_IRQ'(1));
   assign ret_ok     = (state == ST_SERVICE) && (op == OP_RET);

   always_comb begin
      win_id = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) win_id = ID_W'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|eligible) begin
               state_nxt = ST_FIRE;
               fire      = 1'b1;
            end
         end
         ST_FIRE:    state_nxt = ST_ENTRY;
         ST_ENTRY:   if (entry_cnt) state_nxt = ST_SERVICE;
         ST_SERVICE: if (ret_ok) state_nxt = ST_GUARD;
         ST_GUARD:   state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // The pulse, ID and active flag all register on the edge entering FIRE;
   // a new edge on the winning line in that same cycle keeps it pending.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         entry_cnt  <= 1'b0;
         interrupt  <= 1'b0;
         irq_id     <= '0;
         irq_active <= 1'b0;
         pending    <= '0;
         mask       <= '0;
      end else begin
         state     <= state_nxt;
         entry_cnt <= (state == ST_ENTRY) ? ~entry_cnt : 1'b0;
         interrupt <= fire;
         if (fire) begin
            irq_id     <= win_id;
            irq_active <= 1'b1;
         end else if (ret_ok) begin
            irq_active <= 1'b0;
         end
         pending <= (pending & ~(fire ? win_onehot : '0)) | rise;
         if (mask_we) mask <= mask_wdata;
      end
   end

endmodule
